// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch queue: issues sequential reads, buffers responses, handles branch/exception redirects.
// Optional bubble counter output is enabled by defining IF_PREFETCH_PERF_EN.
module if_prefetch #(
   parameter int                ADDR_W     = 32,
   parameter int                DEPTH      = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h0000_0000),
   parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h0000_0080)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         br,
   input  logic [ADDR_W-1:0]            sign,
   input  logic                         except,
   output logic                         imem_req,
   output logic [ADDR_W-1:0]            imem_addr,
   input  logic                         imem_rvalid,
   input  logic [31:0]                  imem_rdata,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ADDR_W-1:0]            pc_out,
   output logic [31:0]                  inst_out,
`ifdef IF_PREFETCH_PERF_EN
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [31:0]                  bubble_cnt
`else
   output logic [$clog2(DEPTH+1)-1:0]   count
`endif
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam int              CNT_W   = $clog2(DEPTH+1);
   localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(DEPTH);

   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              inflight_q, inflight_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] pc_mem_q [DEPTH];
   logic [ADDR_W-1:0] pc_mem_d [DEPTH];
   logic [31:0]       inst_mem_q [DEPTH];
   logic [31:0]       inst_mem_d [DEPTH];

   logic              redirect_s;
   logic              out_valid_s;
   logic              imem_req_s;
   logic              push_s;
   logic              pop_s;
   logic [ADDR_W-1:0] target_s;
   logic [CNT_W:0]    occupancy_s;

   // Handshake decode; the single in-flight slot counts against queue space so a response always fits.
   always_comb begin
      redirect_s  = br | except;
      target_s    = except ? EXC_VECTOR : (sign & {{(ADDR_W-2){1'b1}}, 2'b00});
      occupancy_s = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
      out_valid_s = ~rst & (count_q != {CNT_W{1'b0}});
      imem_req_s  = ~rst & ~redirect_s & (occupancy_s < DEPTH_C);
      push_s      = ~rst & ~redirect_s & imem_rvalid & inflight_q;
      pop_s       = ~redirect_s & out_valid_s & out_ready;
   end

   always_comb begin
      fpc_d      = fpc_q;
      req_pc_d   = req_pc_q;
      inflight_d = inflight_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      if (redirect_s) begin
         // Dropping the in-flight flag turns the outstanding response into a discard.
         fpc_d      = target_s;
         inflight_d = 1'b0;
         wr_ptr_d   = {PTR_W{1'b0}};
         rd_ptr_d   = {PTR_W{1'b0}};
         count_d    = {CNT_W{1'b0}};
      end else begin
         inflight_d = imem_req_s;
         if (imem_req_s) begin
            req_pc_d = fpc_q;
            fpc_d    = fpc_q + ADDR_W'(4);
         end else begin
            req_pc_d = req_pc_q;
         end
         if (push_s) begin
            pc_mem_d[wr_ptr_q]   = req_pc_q;
            inst_mem_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q      <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
         wr_ptr_q   <= {PTR_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
      end else begin
         fpc_q      <= fpc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Queue storage carries no reset; validity is tracked by count and pointers.
   always_ff @(posedge clk) begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
   end

`ifdef IF_PREFETCH_PERF_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      if (redirect_s) begin
         bubble_cnt_d = 32'h0000_0000;
      end else if (!out_valid_s && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 32'h0000_0001;
      end else begin
         bubble_cnt_d = bubble_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_q <= 32'h0000_0000;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
`else
`endif

   assign imem_req  = imem_req_s;
   assign imem_addr = fpc_q;
   assign out_valid = out_valid_s;
   assign pc_out    = out_valid_s ? pc_mem_q[rd_ptr_q] : {ADDR_W{1'b0}};
   assign inst_out  = out_valid_s ? inst_mem_q[rd_ptr_q] : 32'h0000_0000;
   assign count     = rst ? {CNT_W{1'b0}} : count_q;

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: directed vector table, hand sequences, and random traffic
// compared against a queue-based reference model.
module tb_if_prefetch;
   localparam int          ADDR_W   = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC  = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        br = 1'b0;
   logic [31:0] sign = 32'h0;
   logic        except = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic [2:0]  count;
`ifdef IF_PREFETCH_PERF_EN
   logic [31:0] bubble_cnt;
`endif

   if_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VEC)) dut (
      .clk(clk), .rst(rst), .br(br), .sign(sign), .except(except),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .inst_out(inst_out),
`ifdef IF_PREFETCH_PERF_EN
      .count(count), .bubble_cnt(bubble_cnt)
`else
      .count(count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of fetched entries plus the outstanding request.
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
   ent_t        mq[$];
   bit          m_pend = 1'b0;
   logic [31:0] m_pend_pc = 32'h0;
   logic [31:0] m_fpc = RESET_PC;
   logic [31:0] m_bubble = 32'h0;
   bit          mem_pend = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] data_xor = 32'h0;

   logic        s_valid, s_req;
   logic [31:0] s_pc, s_inst, s_addr;
   logic [2:0]  s_cnt;

   task automatic do_cycle(input bit r, input bit b, input bit e, input logic [31:0] sg,
                           input bit rdy, input bit spur);
      bit          exp_valid, exp_req, rv;
      logic [31:0] exp_pc, exp_inst, rd;
      int          exp_cnt;
      @(negedge clk);
      rv = mem_pend | spur;
      rd = mem_pend ? (mem_addr ^ data_xor) : $urandom();
      rst = r; br = b; except = e; sign = sg; out_ready = rdy;
      imem_rvalid = rv; imem_rdata = rd;
      #1;
      exp_valid = !r && (mq.size() != 0);
      exp_pc    = exp_valid ? mq[0].pc : 32'h0;
      exp_inst  = exp_valid ? mq[0].inst : 32'h0;
      exp_cnt   = r ? 0 : mq.size();
      exp_req   = !r && !(b || e) && ((mq.size() + int'(m_pend)) < DEPTH);
      s_valid = out_valid; s_pc = pc_out; s_inst = inst_out; s_cnt = count;
      s_req = imem_req; s_addr = imem_addr;
      check("out_valid", {31'h0, s_valid}, {31'h0, exp_valid});
      check("pc_out", s_pc, exp_pc);
      check("inst_out", s_inst, exp_inst);
      check("count", {29'h0, s_cnt}, exp_cnt);
      check("imem_req", {31'h0, s_req}, {31'h0, exp_req});
      if (exp_req) check("imem_addr", s_addr, m_fpc);
`ifdef IF_PREFETCH_PERF_EN
      if (!r) check("bubble_cnt", bubble_cnt, m_bubble);
`endif
      mem_pend = imem_req;
      mem_addr = imem_addr;
      @(posedge clk);
      if (r) begin
         mq.delete(); m_pend = 1'b0; m_fpc = RESET_PC; m_bubble = 32'h0;
      end else if (b || e) begin
         mq.delete(); m_pend = 1'b0; m_bubble = 32'h0;
         m_fpc = e ? EXC_VEC : (sg & ~32'h3);
      end else begin
         if (!exp_valid && m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 32'h1;
         if (exp_valid && rdy) void'(mq.pop_front());
         if (rv && m_pend) mq.push_back('{m_pend_pc, rd});
         m_pend = exp_req;
         if (exp_req) begin
            m_pend_pc = m_fpc;
            m_fpc     = m_fpc + 32'h4;
         end
      end
   endtask

   typedef struct {
      bit rst; bit br; bit exc; logic [31:0] sign; bit rdy;
      bit e_valid; logic [31:0] e_pc; int e_cnt; bit e_req; logic [31:0] e_addr;
   } vec_t;
   vec_t tbl[25];

   initial begin
      // Memory returns the address as data, so inst_out must track pc_out.
      tbl[0]  = '{1, 0, 0, 32'h0,    1, 0, 32'h0,    0, 0, 32'h0};
      tbl[1]  = '{1, 0, 0, 32'h0,    1, 0, 32'h0,    0, 0, 32'h0};
      tbl[2]  = '{0, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1, 32'h0};
      tbl[3]  = '{0, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1, 32'h4};
      tbl[4]  = '{0, 0, 0, 32'h0,    1, 1, 32'h0,    1, 1, 32'h8};
      tbl[5]  = '{0, 0, 0, 32'h0,    1, 1, 32'h4,    1, 1, 32'hC};
      tbl[6]  = '{0, 0, 0, 32'h0,    0, 1, 32'h8,    1, 1, 32'h10};
      tbl[7]  = '{0, 0, 0, 32'h0,    0, 1, 32'h8,    2, 1, 32'h14};
      tbl[8]  = '{0, 0, 0, 32'h0,    0, 1, 32'h8,    3, 0, 32'h0};
      tbl[9]  = '{0, 0, 0, 32'h0,    0, 1, 32'h8,    4, 0, 32'h0};
      tbl[10] = '{0, 0, 0, 32'h0,    0, 1, 32'h8,    4, 0, 32'h0};
      tbl[11] = '{0, 0, 0, 32'h0,    1, 1, 32'h8,    4, 0, 32'h0};
      tbl[12] = '{0, 0, 0, 32'h0,    1, 1, 32'hC,    3, 1, 32'h18};
      tbl[13] = '{0, 0, 0, 32'h0,    1, 1, 32'h10,   2, 1, 32'h1C};
      tbl[14] = '{0, 0, 0, 32'h0,    1, 1, 32'h14,   2, 1, 32'h20};
      tbl[15] = '{0, 1, 0, 32'h1002, 1, 1, 32'h18,   2, 0, 32'h0};
      tbl[16] = '{0, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1, 32'h1000};
      tbl[17] = '{0, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1, 32'h1004};
      tbl[18] = '{0, 0, 0, 32'h0,    1, 1, 32'h1000, 1, 1, 32'h1008};
      tbl[19] = '{0, 1, 1, 32'h200,  1, 1, 32'h1004, 1, 0, 32'h0};
      tbl[20] = '{0, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1, 32'h80};
      tbl[21] = '{0, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1, 32'h84};
      tbl[22] = '{0, 0, 0, 32'h0,    1, 1, 32'h80,   1, 1, 32'h88};
      tbl[23] = '{1, 0, 0, 32'h0,    1, 0, 32'h0,    0, 0, 32'h0};
      tbl[24] = '{0, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1, 32'h0};

      for (int i = 0; i < 25; i++) begin
         do_cycle(tbl[i].rst, tbl[i].br, tbl[i].exc, tbl[i].sign, tbl[i].rdy, 1'b0);
         check("tbl_valid", {31'h0, s_valid}, {31'h0, tbl[i].e_valid});
         check("tbl_pc", s_pc, tbl[i].e_pc);
         check("tbl_inst", s_inst, tbl[i].e_pc);
         check("tbl_count", {29'h0, s_cnt}, tbl[i].e_cnt);
         check("tbl_req", {31'h0, s_req}, {31'h0, tbl[i].e_req});
         if (tbl[i].e_req) check("tbl_addr", s_addr, tbl[i].e_addr);
      end

      // Fetch address wraps past the top of the address space.
      do_cycle(0, 1, 0, 32'hFFFF_FFFC, 1, 0);
      check("wrap_redirect_noreq", {31'h0, s_req}, 32'h0);
      do_cycle(0, 0, 0, 32'h0, 1, 0);
      check("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
      do_cycle(0, 0, 0, 32'h0, 1, 0);
      check("wrap_addr_zero", s_addr, 32'h0000_0000);
      do_cycle(0, 0, 0, 32'h0, 1, 0);
      check("wrap_head_pc", s_pc, 32'hFFFF_FFFC);

      // Stray read-valid with nothing outstanding must not add an entry.
      for (int i = 0; i < 8; i++) do_cycle(0, 0, 0, 32'h0, 0, 0);
      do_cycle(0, 0, 0, 32'h0, 0, 1);
      do_cycle(0, 0, 0, 32'h0, 0, 0);
      check("spurious_rvalid_count", {29'h0, s_cnt}, 32'd4);
      for (int i = 0; i < 6; i++) do_cycle(0, 0, 0, 32'h0, 1, 0);

      data_xor = 32'hC3C3_5A5A;
      for (int i = 0; i < 600; i++) begin
         bit          r, b, e, rdy, spur;
         logic [31:0] tgt;
         r    = ($urandom_range(0, 39) == 0);
         b    = ($urandom_range(0, 11) == 0);
         e    = ($urandom_range(0, 24) == 0);
         rdy  = ($urandom_range(0, 9) < 7);
         spur = ($urandom_range(0, 4) == 0);
         tgt  = $urandom();
         do_cycle(r, b, e, tgt, rdy, spur);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter ADDR_W, 32, PC and instruction-memory address width.
REQ-002 Parameter DEPTH, 4, prefetch queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-004 Parameter EXC_VECTOR, 32'h0000_0080, fetch address on exception.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 br  in  1  branch redirect request, one-cycle pulse.
REQ-008 sign  in  ADDR_W  branch target, sampled when br=1.
REQ-009 except  in  1  exception redirect request, one-cycle pulse.
REQ-010 imem_req  out  1  instruction read request.
REQ-011 imem_addr  out  ADDR_W  read address, valid when imem_req=1.
REQ-012 imem_rvalid  in  1  read data valid, exactly one cycle after an accepted imem_req.
REQ-013 imem_rdata  in  32  instruction word.
REQ-014 out_valid  out  1  head queue entry available to decode.
REQ-015 out_ready  in  1  decode accepts head entry.
REQ-016 pc_out  out  ADDR_W  PC of head entry; 0 when out_valid=0.
REQ-017 inst_out  out  32  instruction of head entry; 0 when out_valid=0.
REQ-018 count  out  $clog2(DEPTH+1)  current queue occupancy.

Function
REQ-019 Fetch PC register fpc; imem_addr SHALL equal fpc; fpc increments by 4 per issued request, wrapping modulo 2^ADDR_W.
REQ-020 imem_req SHALL assert iff rst=0, no redirect this cycle, and occupancy + in-flight requests < DEPTH (no overflow possible).
REQ-021 At most one request in flight; requests may issue back-to-back every cycle.
REQ-022 On imem_rvalid with a live in-flight request, {PC, imem_rdata} SHALL be pushed at queue tail; imem_rvalid without an outstanding request SHALL be ignored.
REQ-023 Queue is circular FIFO of DEPTH entries; pop on out_valid & out_ready; simultaneous push and pop leave count unchanged; pointers wrap at DEPTH.
REQ-024 out_valid SHALL equal (count != 0); pc_out/inst_out driven from head, combinational from storage.
REQ-025 Latency: request issued cycle t -> entry visible (out_valid=1) in cycle t+2.
REQ-026 Redirect: except has priority over br; in redirect cycle, fpc <= EXC_VECTOR (except) or sign with bits[1:0] forced 0 (br); queue flushed (count=0 next cycle); in-flight response marked dead and discarded on arrival; no request issued that cycle.
REQ-027 Redirect coincident with pop or push: flush wins; popped/pushed entry discarded.
REQ-028 Redirect at cycle t -> first target request cycle t+1 -> out_valid with pc_out=target cycle t+3.
REQ-029 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-030 While rst=1: fpc=RESET_PC, count=0, queue pointers 0, in-flight flag 0, imem_req=0, out_valid=0, pc_out=0, inst_out=0.
REQ-031 rst asserted mid-operation overrides redirect, push and pop; pending response discarded.
REQ-032 First request (addr RESET_PC) in first cycle with rst=0.

Configuration
REQ-033 Macro IF_PREFETCH_PERF_EN: when defined, adds output bubble_cnt [31:0] counting cycles with out_valid=0 and rst=0, cleared by rst and by redirect, saturating at 32'hFFFF_FFFF; when undefined, port and counter absent, all other behaviour identical.

Verification
REQ-034 Reset release, out_ready=1, memory returns addr as data -> pc_out 0,4,8,... one per cycle from cycle 2, inst_out==pc_out.
REQ-035 out_ready=0 for 10 cycles -> count saturates at DEPTH, imem_req=0 once occupancy+in-flight=DEPTH, no entry lost; release -> pops in order.
REQ-036 br=1, sign=32'h0000_1002 with queue non-empty -> count=0 next cycle, next request addr 32'h0000_1000, in-flight old response not delivered.
REQ-037 br=1 and except=1 same cycle, sign=32'h200 -> next fetch at 32'h80.
REQ-038 fpc=32'hFFFF_FFFC -> following request addr 32'h0000_0000; rst mid-stream -> next cycle out_valid=0, count=0, first request RESET_PC.
